mc_controller: RTL and testbench

//  Multicycle control unit for the ARM-subset CPU: sequences a shared-ALU, single-memory datapath over 3-5 cycles/instr.

---
 rtl/mc_pkg.sv | 85 ++++++++
 rtl/mc_controller_if.sv | 38 +++
 rtl/mc_main_fsm.sv | 120 ++++++++++++
 rtl/mc_controller.sv | 123 ++++++++++++
 tb/tb_mc_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
//============================================================================
// Package     : mc_pkg
// Description : Shared types, encodings and the ARM condition check for the
//               multicycle control unit.
// Revision    : 1.0 - initial release
//============================================================================
package mc_pkg;

    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned ALUCTRL_W = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [ALUCTRL_W-1:0] c_ALU_ADD = 2'b00;
    localparam logic [ALUCTRL_W-1:0] c_ALU_SUB = 2'b01;
    localparam logic [ALUCTRL_W-1:0] c_ALU_AND = 2'b10;
    localparam logic [ALUCTRL_W-1:0] c_ALU_ORR = 2'b11;

    localparam logic [1:0] c_SRCB_RD2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURES = 2'b10;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;
    localparam logic [1:0] c_OP_UND = 2'b11;

    localparam logic [3:0] c_COND_EQ = 4'b0000;
    localparam logic [3:0] c_COND_NE = 4'b0001;
    localparam logic [3:0] c_COND_CS = 4'b0010;
    localparam logic [3:0] c_COND_CC = 4'b0011;
    localparam logic [3:0] c_COND_MI = 4'b0100;
    localparam logic [3:0] c_COND_PL = 4'b0101;
    localparam logic [3:0] c_COND_VS = 4'b0110;
    localparam logic [3:0] c_COND_VC = 4'b0111;
    localparam logic [3:0] c_COND_HI = 4'b1000;
    localparam logic [3:0] c_COND_LS = 4'b1001;
    localparam logic [3:0] c_COND_GE = 4'b1010;
    localparam logic [3:0] c_COND_LT = 4'b1011;
    localparam logic [3:0] c_COND_GT = 4'b1100;
    localparam logic [3:0] c_COND_LE = 4'b1101;
    localparam logic [3:0] c_COND_AL = 4'b1110;

    // Flags are ordered {N, Z, C, V}; the reserved code 1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [FLAG_W-1:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            c_COND_EQ: cond_check = z;
            c_COND_NE: cond_check = ~z;
            c_COND_CS: cond_check = c;
            c_COND_CC: cond_check = ~c;
            c_COND_MI: cond_check = n;
            c_COND_PL: cond_check = ~n;
            c_COND_VS: cond_check = v;
            c_COND_VC: cond_check = ~v;
            c_COND_HI: cond_check = c & ~z;
            c_COND_LS: cond_check = ~c | z;
            c_COND_GE: cond_check = (n == v);
            c_COND_LT: cond_check = (n != v);
            c_COND_GT: cond_check = ~z & (n == v);
            c_COND_LE: cond_check = z | (n != v);
            c_COND_AL: cond_check = 1'b1;
            default:   cond_check = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
//============================================================================
// Interface   : mc_controller_if
// Description : Instruction/flag inputs and datapath control outputs between
//               the multicycle controller (master) and datapath (slave).
// Revision    : 1.0 - initial release
//============================================================================
interface mc_controller_if;
    import mc_pkg::*;

    logic [19:0]          Instr;
    logic [FLAG_W-1:0]    ALUFlags;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           RegSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

endinterface
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
//============================================================================
// Module      : mc_main_fsm
// Description : Main sequencing FSM: state register, next-state logic and
//               ungated per-state Moore control outputs.
// Revision    : 1.0 - initial release
//============================================================================
module mc_main_fsm
    import mc_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] i_op,
    input  wire logic       i_imm,
    input  wire logic       i_load,
    output logic            o_reg_w,
    output logic            o_mem_w,
    output logic            o_ir_write,
    output logic            o_next_pc,
    output logic            o_branch,
    output logic            o_alu_op,
    output logic            o_adr_src,
    output logic            o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic [1:0]      o_result_src,
    output state_t          o_state
);

    state_t r_state;
    state_t w_state_next;
    state_t w_out_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    c_OP_MEM: w_state_next = S_MEMADR;
                    c_OP_DP:  w_state_next = i_imm ? S_EXECUTEI : S_EXECUTER;
                    c_OP_BR:  w_state_next = S_BRANCH;
                    default:  w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = i_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = S_MEMWB;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // While reset is high the mux selects mirror FETCH but no enable fires.
    assign w_out_state = reset ? S_FETCH : r_state;

    always_comb begin
        o_reg_w      = 1'b0;
        o_mem_w      = 1'b0;
        o_ir_write   = 1'b0;
        o_next_pc    = 1'b0;
        o_branch     = 1'b0;
        o_alu_op     = 1'b0;
        o_adr_src    = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = c_SRCB_RD2;
        o_result_src = c_RES_ALUOUT;
        case (w_out_state)
            S_FETCH: begin
                o_ir_write   = 1'b1;
                o_next_pc    = 1'b1;
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = c_SRCB_FOUR;
                o_result_src = c_RES_ALURES;
            end
            S_DECODE: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = c_SRCB_FOUR;
                o_result_src = c_RES_ALURES;
            end
            S_MEMADR:   o_alu_src_b = c_SRCB_IMM;
            S_MEMREAD:  o_adr_src = 1'b1;
            S_MEMWB: begin
                o_result_src = c_RES_DATA;
                o_reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src = 1'b1;
                o_mem_w   = 1'b1;
            end
            S_EXECUTER: o_alu_op = 1'b1;
            S_EXECUTEI: begin
                o_alu_src_b = c_SRCB_IMM;
                o_alu_op    = 1'b1;
            end
            S_ALUWB:    o_reg_w = 1'b1;
            S_BRANCH: begin
                o_alu_src_b  = c_SRCB_IMM;
                o_result_src = c_RES_ALURES;
                o_branch     = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            o_ir_write = 1'b0;
            o_next_pc  = 1'b0;
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
//============================================================================
// Module      : mc_controller
// Description : Multicycle ARM-subset control unit: ALU decode, condition
//               check, NZCV flag register and conditional write gating.
//               Define MC_DBG_STATE_EN to expose state_dbg and illegal_op.
// Revision    : 1.0 - initial release
//============================================================================
module mc_controller
    import mc_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    mc_controller_if.master   bus
`ifdef MC_DBG_STATE_EN
    ,
    output logic [3:0]        state_dbg,
    output logic              illegal_op
`endif
);

    logic [1:0]           w_op;
    logic                 w_imm;
    logic [3:0]           w_cmd;
    logic                 w_s;
    logic [3:0]           w_rd;
    logic [3:0]           w_cond;
    logic                 w_unused;

    logic                 w_reg_w, w_mem_w, w_ir_write, w_next_pc, w_branch, w_alu_op;
    logic                 w_adr_src, w_alu_src_a;
    logic [1:0]           w_alu_src_b, w_result_src;
    state_t               w_state;

    logic [ALUCTRL_W-1:0] w_alu_ctrl;
    logic [1:0]           w_flag_w;
    logic                 w_cond_ex;
    logic                 w_exec;

    logic [FLAG_W-1:0]    r_flags;
    logic                 r_cond_ex;

    // The IR port carries Instr[31:12], so full-word bit k sits at index k-12.
    assign w_cond   = bus.Instr[19:16];
    assign w_op     = bus.Instr[15:14];
    assign w_imm    = bus.Instr[13];
    assign w_cmd    = bus.Instr[12:9];
    assign w_s      = bus.Instr[8];
    assign w_rd     = bus.Instr[3:0];
    assign w_unused = ^bus.Instr[7:4];

    mc_main_fsm u_main_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_op         (w_op),
        .i_imm        (w_imm),
        .i_load       (w_s),
        .o_reg_w      (w_reg_w),
        .o_mem_w      (w_mem_w),
        .o_ir_write   (w_ir_write),
        .o_next_pc    (w_next_pc),
        .o_branch     (w_branch),
        .o_alu_op     (w_alu_op),
        .o_adr_src    (w_adr_src),
        .o_alu_src_a  (w_alu_src_a),
        .o_alu_src_b  (w_alu_src_b),
        .o_result_src (w_result_src),
        .o_state      (w_state)
    );

    always_comb begin
        w_alu_ctrl = c_ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (w_cmd)
                4'b0100: begin w_alu_ctrl = c_ALU_ADD; w_flag_w = {w_s, w_s};  end
                4'b0010: begin w_alu_ctrl = c_ALU_SUB; w_flag_w = {w_s, w_s};  end
                4'b0000: begin w_alu_ctrl = c_ALU_AND; w_flag_w = {w_s, 1'b0}; end
                4'b1100: begin w_alu_ctrl = c_ALU_ORR; w_flag_w = {w_s, 1'b0}; end
                default: begin w_alu_ctrl = c_ALU_ADD; w_flag_w = 2'b00;       end
            endcase
        end
    end

    assign w_cond_ex = cond_check(w_cond, r_flags);
    assign w_exec    = (w_state == S_EXECUTER) || (w_state == S_EXECUTEI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= '0;
            r_cond_ex <= 1'b0;
        end else begin
            if (w_state == S_DECODE) begin
                r_cond_ex <= w_cond_ex;
            end
            if (w_exec && r_cond_ex && w_flag_w[1]) begin
                r_flags[3:2] <= bus.ALUFlags[3:2];
            end
            if (w_exec && r_cond_ex && w_flag_w[0]) begin
                r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    assign bus.RegWrite   = w_reg_w & r_cond_ex;
    assign bus.MemWrite   = w_mem_w & r_cond_ex;
    assign bus.PCWrite    = w_next_pc | (w_branch & r_cond_ex) | (w_reg_w & r_cond_ex & (w_rd == 4'hF));
    assign bus.IRWrite    = w_ir_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.RegSrc     = {(w_op == c_OP_MEM), (w_op == c_OP_BR)};
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ImmSrc     = w_op;
    assign bus.ALUControl = w_alu_ctrl;

`ifdef MC_DBG_STATE_EN
    assign state_dbg  = w_state;
    assign illegal_op = (w_state == S_DECODE) && (w_op == c_OP_UND);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
//============================================================================
// Module      : tb_mc_controller
// Description : Directed scoreboard bench for mc_controller (default build;
//               debug ports connected when MC_DBG_STATE_EN is defined).
// Revision    : 1.0 - initial release
//============================================================================
module tb_mc_controller;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] aluc;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    string tag_q[$];
    logic [1:0] g_regsrc;
    logic [1:0] g_immsrc;

    mc_controller_if bus();

`ifdef MC_DBG_STATE_EN
    logic [3:0] state_dbg;
    logic       illegal_op;
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg), .illegal_op(illegal_op));
`else
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input string t, input logic pcw, input logic memw, input logic regw,
                        input logic irw, input logic adr, input logic srca, input logic [1:0] srcb,
                        input logic [1:0] res, input logic [1:0] aluc);
        exp_t e;
        e = '{pcw: pcw, memw: memw, regw: regw, irw: irw, adr: adr, srca: srca,
              srcb: srcb, res: res, aluc: aluc, regsrc: g_regsrc, immsrc: g_immsrc};
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic p_fetch(input string t);
        push({t, "/FETCH"}, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00);
    endtask

    task automatic p_decode(input string t);
        push({t, "/DECODE"}, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
    endtask

    task automatic p_reset(input string t);
        push({t, "/RESET"}, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00);
    endtask

    task automatic start(input logic [19:0] instr, input logic [3:0] flags,
                         input logic [1:0] regsrc, input logic [1:0] immsrc);
        bus.Instr    = instr;
        bus.ALUFlags = flags;
        g_regsrc     = regsrc;
        g_immsrc     = immsrc;
    endtask

    // Each queued entry is one cycle: sample at negedge, then step past the next posedge.
    task automatic drain();
        exp_t  e;
        exp_t  obs;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            @(negedge clk);
            obs = '{pcw: bus.PCWrite, memw: bus.MemWrite, regw: bus.RegWrite, irw: bus.IRWrite,
                    adr: bus.AdrSrc, srca: bus.ALUSrcA, srcb: bus.ALUSrcB, res: bus.ResultSrc,
                    aluc: bus.ALUControl, regsrc: bus.RegSrc, immsrc: bus.ImmSrc};
            n_tests++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk4(input string t, input logic [3:0] obs, input logic [3:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, expv);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start(20'h00000, 4'b0000, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        p_reset("rst0");
        drain();
        chk4("rst_flags", dut.r_flags, 4'b0000);
        chk4("rst_condex", {3'b000, dut.r_cond_ex}, 4'b0000);
        reset = 1'b0;

        // LDR R2,[R1,#4]
        start(20'hE5912, 4'b0000, 2'b10, 2'b01);
        p_fetch("ldr"); p_decode("ldr");
        push("ldr/MEMADR",  0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        push("ldr/MEMREAD", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        push("ldr/MEMWB",   0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        drain();

        // STR R2,[R1]
        start(20'hE5812, 4'b0000, 2'b10, 2'b01);
        p_fetch("str"); p_decode("str");
        push("str/MEMADR",   0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        push("str/MEMWRITE", 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        drain();

        // SUBS R3,R1,R2 with Z result
        start(20'hE0513, 4'b0100, 2'b00, 2'b00);
        p_fetch("subs"); p_decode("subs");
        push("subs/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        push("subs/ALUWB", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("subs_flags", dut.r_flags, 4'b0100);

        // BEQ taken (Z=1)
        start(20'h0A000, 4'b1011, 2'b01, 2'b10);
        p_fetch("beq_t"); p_decode("beq_t");
        push("beq_t/BRANCH", 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
        drain();

        // ADDNE with Z=1: suppressed
        start(20'h10813, 4'b1011, 2'b00, 2'b00);
        p_fetch("addne"); p_decode("addne");
        push("addne/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        push("addne/ALUWB", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("addne_flags", dut.r_flags, 4'b0100);

        // SUBSNE with Z=1: flags must not load
        start(20'h10513, 4'b1011, 2'b00, 2'b00);
        p_fetch("subsne"); p_decode("subsne");
        push("subsne/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        push("subsne/ALUWB", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("subsne_flags", dut.r_flags, 4'b0100);

        // SUBS clearing Z, setting C,V
        start(20'hE0513, 4'b0011, 2'b00, 2'b00);
        p_fetch("subs2"); p_decode("subs2");
        push("subs2/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        push("subs2/ALUWB", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("subs2_flags", dut.r_flags, 4'b0011);

        // BEQ not taken (Z=0)
        start(20'h0A000, 4'b0100, 2'b01, 2'b10);
        p_fetch("beq_n"); p_decode("beq_n");
        push("beq_n/BRANCH", 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00);
        drain();

        // ANDS: only N,Z update
        start(20'hE0113, 4'b1100, 2'b00, 2'b00);
        p_fetch("ands"); p_decode("ands");
        push("ands/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
        push("ands/ALUWB", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("ands_flags", dut.r_flags, 4'b1111);

        // ORR PC,R0,#imm: immediate path and Rd==15 PC write
        start(20'hE380F, 4'b0000, 2'b00, 2'b00);
        p_fetch("orr"); p_decode("orr");
        push("orr/EXECI", 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b11);
        push("orr/ALUWB", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();
        chk4("orr_flags", dut.r_flags, 4'b1111);

        // Reserved condition 1111 never executes
        start(20'hF0813, 4'b0000, 2'b00, 2'b00);
        p_fetch("nv"); p_decode("nv");
        push("nv/EXECR", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        push("nv/ALUWB", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        drain();

        // Op=11: two cycles, straight back to FETCH
        start(20'hEC000, 4'b0000, 2'b00, 2'b11);
        p_fetch("op11"); p_decode("op11");
        drain();
`ifdef MC_DBG_STATE_EN
        chk4("op11_dbg_state", state_dbg, 4'd0);
`endif

        // LDR aborted by reset in MEMWB
        start(20'hE5912, 4'b0000, 2'b10, 2'b01);
        p_fetch("ldr_rst"); p_decode("ldr_rst");
        push("ldr_rst/MEMADR",  0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        push("ldr_rst/MEMREAD", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        drain();
        reset = 1'b1;
        p_reset("ldr_rst/inMEMWB");
        drain();
        p_reset("ldr_rst/held");
        drain();
        chk4("ldr_rst_flags", dut.r_flags, 4'b0000);
        reset = 1'b0;
        p_fetch("post_rst");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
